// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Types and constants shared by the hazard controller and its comparator.
package pipeline_hazard_ctrl_pkg;
`include "pipe_ctrl_defs.vh"

  typedef enum logic {
    ST_RUN      = `PHC_ST_RUN,
    ST_MDU_WAIT = `PHC_ST_MDU_WAIT
  } state_t;

  localparam logic [4:0] REG_X0          = `PHC_REG_X0;
  localparam int         TIMEOUT_DEFAULT = `PHC_TIMEOUT_DEFAULT;

  // Bit order matches the port list so the bundle can be printed as one vector.
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;
    logic id_ex_hold;
    logic ex_mem_bubble;
    logic ex_mem_hold;
    logic mem_wb_bubble;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN   = '{pc_write: 1'b1, if_id_write: 1'b1, default: 1'b0};
  localparam ctrl_t CTRL_RESET = '{if_id_flush: 1'b1, id_ex_bubble: 1'b1, ex_mem_bubble: 1'b1,
                                   mem_wb_bubble: 1'b1, default: 1'b0};

endpackage

// File: rtl/pipe_ctrl_defs.vh
// Shared encodings for the pipeline control slice: FSM states, x0, default wait timeout.
`ifndef PIPE_CTRL_DEFS_VH
`define PIPE_CTRL_DEFS_VH

`define PHC_ST_RUN          1'b0
`define PHC_ST_MDU_WAIT     1'b1
`define PHC_REG_X0          5'd0
`define PHC_TIMEOUT_DEFAULT 256

`endif

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Load-use comparator: flags an ID source that matches the rd of a load in EX.
// Purely combinational; x0 never creates a dependency.
module load_use_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  output logic       load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
  assign load_use = ex_mem_read && (ex_rd != REG_X0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory wait > MDU busy > taken branch > load-use.
// Control outputs are zero-latency; wait_cnt, hang_err and stall_count are registered.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             ex_mdu_start,
  input  logic             mdu_done,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             id_ex_hold,
  output logic             ex_mem_bubble,
  output logic             ex_mem_hold,
  output logic             mem_wb_bubble,
  output logic             hang_err,
  output logic [CNT_W-1:0] stall_count
);

  localparam int WC_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(TIMEOUT - 1);

  state_t          state;
  state_t          state_nxt;
  logic [WC_W-1:0] wait_cnt;
  logic            mem_wait;
  logic            mdu_busy;
  logic            waiting;
  logic            load_use;
  ctrl_t           ctrl;

  load_use_detect u_load_use_detect (
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .load_use    (load_use)
  );

  assign mem_wait = dmem_req && !dmem_ready;
  assign mdu_busy = ((state == ST_RUN) && ex_mdu_start && !mdu_done) ||
                    ((state == ST_MDU_WAIT) && !mdu_done);
  assign waiting  = mem_wait || mdu_busy;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:      if (ex_mdu_start && !mdu_done && !mem_wait) state_nxt = ST_MDU_WAIT;
      ST_MDU_WAIT: if (mdu_done && !mem_wait) state_nxt = ST_RUN;
      default:     state_nxt = ST_RUN;
    endcase
  end

  // A frozen EX instruction makes branch and load-use decisions meaningless, hence the strict order.
  always_comb begin
    ctrl = CTRL_RUN;
    if (reset) begin
      ctrl = CTRL_RESET;
    end else if (mem_wait) begin
      ctrl.pc_write      = 1'b0;
      ctrl.if_id_write   = 1'b0;
      ctrl.id_ex_hold    = 1'b1;
      ctrl.ex_mem_hold   = 1'b1;
      ctrl.mem_wb_bubble = 1'b1;
    end else if (mdu_busy) begin
      ctrl.pc_write      = 1'b0;
      ctrl.if_id_write   = 1'b0;
      ctrl.id_ex_hold    = 1'b1;
      ctrl.ex_mem_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      ctrl.if_id_flush   = 1'b1;
      ctrl.id_ex_bubble  = 1'b1;
    end else if (load_use) begin
      ctrl.pc_write      = 1'b0;
      ctrl.if_id_write   = 1'b0;
      ctrl.id_ex_bubble  = 1'b1;
    end
  end

  assign pc_write      = ctrl.pc_write;
  assign if_id_write   = ctrl.if_id_write;
  assign if_id_flush   = ctrl.if_id_flush;
  assign id_ex_bubble  = ctrl.id_ex_bubble;
  assign id_ex_hold    = ctrl.id_ex_hold;
  assign ex_mem_bubble = ctrl.ex_mem_bubble;
  assign ex_mem_hold   = ctrl.ex_mem_hold;
  assign mem_wb_bubble = ctrl.mem_wb_bubble;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_RUN;
      wait_cnt    <= '0;
      hang_err    <= 1'b0;
      stall_count <= '0;
    end else begin
      state <= state_nxt;
      // wait_cnt parks at TIMEOUT-1 so the hang condition stays asserted for the rest of the wait.
      if (waiting) begin
        if (wait_cnt == WC_MAX) hang_err <= 1'b1;
        else                    wait_cnt <= wait_cnt + WC_W'(1);
      end else begin
        wait_cnt <= '0;
      end
      if (!ctrl.pc_write && (stall_count != {CNT_W{1'b1}})) begin
        stall_count <= stall_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scenario bench for pipeline_hazard_ctrl with a queue of expected per-cycle control, hang and stall count.
module tb_pipeline_hazard_ctrl;

  localparam logic [7:0] C_NORM = 8'b1100_0000;
  localparam logic [7:0] C_LU   = 8'b0001_0000;
  localparam logic [7:0] C_BR   = 8'b1111_0000;
  localparam logic [7:0] C_MDU  = 8'b0000_1100;
  localparam logic [7:0] C_MEMW = 8'b0000_1011;
  localparam logic [7:0] C_RST  = 8'b0011_0101;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
  logic        ex_mdu_start, mdu_done, dmem_req, dmem_ready;
  logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold;
  logic        ex_mem_bubble, ex_mem_hold, mem_wb_bubble, hang_err;
  logic [15:0] stall_count;
  logic [7:0]  act;

  typedef struct {
    logic [7:0]  ctrl;
    logic        hang;
    int unsigned stall;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned exp_stall = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.CNT_W(16), .TIMEOUT(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .ex_rd           (ex_rd),
    .ex_mem_read     (ex_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .ex_mdu_start    (ex_mdu_start),
    .mdu_done        (mdu_done),
    .dmem_req        (dmem_req),
    .dmem_ready      (dmem_ready),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .if_id_flush     (if_id_flush),
    .id_ex_bubble    (id_ex_bubble),
    .id_ex_hold      (id_ex_hold),
    .ex_mem_bubble   (ex_mem_bubble),
    .ex_mem_hold     (ex_mem_hold),
    .mem_wb_bubble   (mem_wb_bubble),
    .hang_err        (hang_err),
    .stall_count     (stall_count)
  );

  assign act = {pc_write, if_id_write, if_id_flush, id_ex_bubble,
                id_ex_hold, ex_mem_bubble, ex_mem_hold, mem_wb_bubble};

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
    ex_branch_taken = 1'b0; ex_mdu_start = 1'b0; mdu_done = 1'b0;
    dmem_req = 1'b0; dmem_ready = 1'b1;
  endtask

  // Inputs are already applied; expectation is queued, outputs are sampled at the falling edge.
  task automatic cycle(input string name, input logic [7:0] ctrl, input logic hang);
    exp_t e;
    e.ctrl = ctrl; e.hang = hang; e.stall = exp_stall; e.name = name;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (act !== e.ctrl) begin
      errors++;
      $display("FAIL %s ctrl got %b want %b", e.name, act, e.ctrl);
    end
    checks++;
    if (hang_err !== e.hang) begin
      errors++;
      $display("FAIL %s hang_err got %b want %b", e.name, hang_err, e.hang);
    end
    checks++;
    if (stall_count !== 16'(e.stall)) begin
      errors++;
      $display("FAIL %s stall_count got %0d want %0d", e.name, stall_count, e.stall);
    end
    if (reset) exp_stall = 0;
    else if (!e.ctrl[7]) exp_stall++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; idle();
    cycle("reset", C_RST, 1'b0);
    reset = 1'b0;
    cycle("after_reset", C_NORM, 1'b0);
  endtask

  task automatic test_load_use();
    ex_mem_read = 1'b1; ex_rd = 5'd5;
    id_rs1 = 5'd5; id_uses_rs1 = 1'b1; id_rs2 = 5'd1; id_uses_rs2 = 1'b1;
    cycle("lu_rs1", C_LU, 1'b0);
    ex_mem_read = 1'b0;
    cycle("lu_rs1_release", C_NORM, 1'b0);
    ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd3; id_rs2 = 5'd7;
    cycle("lu_rs2", C_LU, 1'b0);
    ex_mem_read = 1'b0;
    cycle("lu_rs2_release", C_NORM, 1'b0);
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    cycle("lu_x0", C_NORM, 1'b0);
    ex_rd = 5'd9; id_rs1 = 5'd9; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    cycle("lu_unused_src", C_NORM, 1'b0);
    ex_mem_read = 1'b0; id_uses_rs1 = 1'b1;
    cycle("lu_not_load", C_NORM, 1'b0);
    idle();
  endtask

  task automatic test_branch();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    ex_branch_taken = 1'b1;
    cycle("branch_over_lu", C_BR, 1'b0);
    idle();
    cycle("branch_after", C_NORM, 1'b0);
  endtask

  task automatic test_mdu();
    ex_mdu_start = 1'b1; mdu_done = 1'b0;
    for (int i = 0; i < 5; i++) cycle($sformatf("mdu_wait_%0d", i), C_MDU, 1'b0);
    mdu_done = 1'b1;
    cycle("mdu_done", C_NORM, 1'b0);
    idle();
    cycle("mdu_back_in_run", C_NORM, 1'b0);
    ex_mdu_start = 1'b1; mdu_done = 1'b1;
    cycle("mdu_single", C_NORM, 1'b0);
    idle();
    cycle("mdu_single_after", C_NORM, 1'b0);
  endtask

  task automatic test_mdu_mem();
    ex_mdu_start = 1'b1; mdu_done = 1'b0;
    cycle("mm_mdu", C_MDU, 1'b0);
    dmem_req = 1'b1; dmem_ready = 1'b0;
    cycle("mm_memw0", C_MEMW, 1'b0);
    mdu_done = 1'b1;
    cycle("mm_memw1", C_MEMW, 1'b0);
    cycle("mm_memw2", C_MEMW, 1'b0);
    dmem_ready = 1'b1;
    cycle("mm_release", C_NORM, 1'b0);
    idle();
    cycle("mm_back_in_run", C_NORM, 1'b0);
  endtask

  task automatic test_timeout();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int k = 1; k <= 10; k++) cycle($sformatf("to_wait_%0d", k), C_MEMW, (k >= 9));
    dmem_ready = 1'b1;
    cycle("to_ready", C_NORM, 1'b1);
    idle();
    cycle("to_sticky", C_NORM, 1'b1);
    reset = 1'b1;
    cycle("to_reset", C_RST, 1'b1);
    reset = 1'b0;
    cycle("to_cleared", C_NORM, 1'b0);
  endtask

  task automatic test_reset_mid_mdu();
    ex_mdu_start = 1'b1; mdu_done = 1'b0;
    for (int i = 0; i < 3; i++) cycle($sformatf("rm_mdu_%0d", i), C_MDU, 1'b0);
    reset = 1'b1;
    cycle("rm_reset", C_RST, 1'b0);
    reset = 1'b0; idle();
    cycle("rm_run", C_NORM, 1'b0);
    cycle("rm_run2", C_NORM, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_branch();
    test_mdu();
    test_mdu_mem();
    test_timeout();
    test_reset_mid_mdu();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
